// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM front-end controller and the CAM itself.
package cam_pkg;

    localparam int CAM_DATA_WIDTH = 32;
    localparam int CAM_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SEARCH = 2'd2,
        OP_INSERT = 2'd3
    } cam_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ALLOC = 3'd3,
        RESP  = 3'd4
    } cam_ctrl_state_e;

endpackage

// File: rtl/cam_ctrl.sv
// Single-command-in-flight front-end for the CAM: strobes the CAM port set, captures
// the result CAM_LAT cycles later and holds one response until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | one CAM strobe is high this cycle
// WAIT  | counting down to the cycle the CAM result is valid
// ALLOC | INSERT missed: writing the key at the victim pointer
// RESP  | response held until rsp_ready_i
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int CAM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_index_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  cam_read_enable_o,
    output logic                  cam_write_enable_o,
    output logic                  cam_search_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [DATA_WIDTH-1:0] cam_write_data_o,
    output logic [DATA_WIDTH-1:0] cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic                  cam_search_valid_i,
    input  logic [DATA_WIDTH-1:0] cam_read_value_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    localparam int LAT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    cam_ctrl_state_e       state_q, state_d;
    cam_op_e               op_q, op_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] victim_q, victim_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  sr_en_q, sr_en_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] sr_data_q, sr_data_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        data_d      = data_q;
        lat_d       = lat_q;
        victim_d    = victim_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_index_d = rsp_index_q;
        rsp_data_d  = rsp_data_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        sr_en_d     = 1'b0;
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        sr_data_d   = sr_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d        = cam_op_e'(cmd_op_i);
                    idx_d       = cmd_index_i;
                    data_d      = cmd_data_i;
                    cmd_ready_d = 1'b0;
                    state_d     = ISSUE;
                    // Strobes are registered, so they are launched here to be high during ISSUE.
                    case (cam_op_e'(cmd_op_i))
                        OP_READ: begin
                            rd_en_d  = 1'b1;
                            rd_idx_d = cmd_index_i;
                        end
                        OP_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_idx_d  = cmd_index_i;
                            wr_data_d = cmd_data_i;
                        end
                        default: begin
                            sr_en_d   = 1'b1;
                            sr_data_d = cmd_data_i;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (op_q == OP_WRITE) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_index_d = idx_q;
                    rsp_data_d  = data_q;
                    state_d     = RESP;
                end else begin
                    lat_d   = LAT_W'(CAM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                end else if (op_q == OP_READ) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = cam_read_valid_i;
                    rsp_index_d = idx_q;
                    rsp_data_d  = cam_read_value_i;
                    state_d     = RESP;
                end else if (op_q == OP_INSERT && !cam_search_valid_i) begin
                    wr_en_d   = 1'b1;
                    wr_idx_d  = victim_q;
                    wr_data_d = data_q;
                    state_d   = ALLOC;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = cam_search_valid_i;
                    rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
                    rsp_data_d  = data_q;
                    state_d     = RESP;
                end
            end
            ALLOC: begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_index_d = victim_q;
                rsp_data_d  = data_q;
                victim_d    = victim_q + ADDR_WIDTH'(1);
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            idx_q       <= '0;
            data_q      <= '0;
            lat_q       <= '0;
            victim_q    <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            sr_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            sr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            lat_q       <= lat_d;
            victim_q    <= victim_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            sr_en_q     <= sr_en_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            sr_data_q   <= sr_data_d;
        end
    end

    assign cmd_ready_o         = cmd_ready_q;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_hit_o           = rsp_hit_q;
    assign rsp_index_o         = rsp_index_q;
    assign rsp_data_o          = rsp_data_q;
    assign cam_read_enable_o   = rd_en_q;
    assign cam_write_enable_o  = wr_en_q;
    assign cam_search_enable_o = sr_en_q;
    assign cam_read_index_o    = rd_idx_q;
    assign cam_write_index_o   = wr_idx_q;
    assign cam_write_data_o    = wr_data_q;
    assign cam_search_data_o   = sr_data_q;

endmodule
